uart_tx_block: RTL and testbench

// - Serial UART transmitter; the transmit-side counterpart of the lab's UART receiver datapath.
// - Accepts a parallel byte on a start strobe and shifts out one frame: start bit, data LSB-first, stop bit.
// - Bit timing comes from an internal rolling bit-period counter; the bit index comes from a second counter.
// - Sits between the host-side register interface and the serial line pin.
//

---
 rtl/uart_tx_block.sv | 176 +++++++++++++++++
 tb/tb_uart_tx_block.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_block.sv
// uart_tx_block: UART transmitter, start + LSB-first data + stop bit.
// Build option: define UART_TX_PARITY_EN to add an even-parity bit.
module uart_tx_block #(
    parameter int NUM_DATA_BITS = 8,
    parameter int CLKS_PER_BIT  = 10
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     tx_start,
    input  logic [NUM_DATA_BITS-1:0] tx_data,
    output logic                     serial_out,
    output logic                     tx_busy,
    output logic                     tx_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam int IDX_W = $clog2(NUM_DATA_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT);
    localparam logic [IDX_W-1:0] IDX_ZERO = '0;
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t                   state_q, state_d;
    logic [NUM_DATA_BITS-1:0] shift_q, shift_d;
    logic [NUM_DATA_BITS-1:0] shift_nxt;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic                     serial_q, serial_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     rollover;
`ifdef UART_TX_PARITY_EN
    logic                     parity_q, parity_d;
`endif

    assign rollover  = (cnt_q == CNT_MAX);
    assign shift_nxt = shift_q >> 1;

    // Next-state, next-output and counter logic; outputs are
    // computed for the cycle after the edge so they leave flops.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        serial_d = serial_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif

        // Bit-period counter rolls 1..CLKS_PER_BIT outside IDLE.
        if (state_q != S_IDLE) begin
            cnt_d = rollover ? CNT_ONE : cnt_q + CNT_ONE;
        end

        unique case (state_q)
            S_IDLE: begin
                serial_d = 1'b1;
                busy_d   = 1'b0;
                cnt_d    = CNT_ZERO;
                idx_d    = IDX_ZERO;
                if (tx_start) begin
                    state_d  = S_START;
                    shift_d  = tx_data;
                    cnt_d    = CNT_ONE;
                    serial_d = 1'b0;
                    busy_d   = 1'b1;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^tx_data;
`endif
                end
            end

            S_START: begin
                if (rollover) begin
                    state_d  = S_DATA;
                    idx_d    = IDX_ZERO;
                    serial_d = shift_q[0];
                end
            end

            S_DATA: begin
                if (rollover) begin
                    if (idx_q == IDX_LAST) begin
                        idx_d = IDX_ZERO;
`ifdef UART_TX_PARITY_EN
                        state_d  = S_PARITY;
                        serial_d = parity_q;
`else
                        state_d  = S_STOP;
                        serial_d = 1'b1;
`endif
                    end else begin
                        idx_d    = idx_q + IDX_ONE;
                        shift_d  = shift_nxt;
                        serial_d = shift_nxt[0];
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (rollover) begin
                    state_d  = S_STOP;
                    serial_d = 1'b1;
                end
            end
`endif

            S_STOP: begin
                if (rollover) begin
                    state_d  = S_IDLE;
                    cnt_d    = CNT_ZERO;
                    serial_d = 1'b1;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                end
            end

            default: begin
                state_d  = S_IDLE;
                cnt_d    = CNT_ZERO;
                idx_d    = IDX_ZERO;
                serial_d = 1'b1;
                busy_d   = 1'b0;
            end
        endcase
    end

    // FSM, datapath and registered outputs; reset abandons any frame.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= S_IDLE;
            shift_q  <= '0;
            cnt_q    <= CNT_ZERO;
            idx_q    <= IDX_ZERO;
            serial_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            serial_q <= serial_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign serial_out = serial_q;
    assign tx_busy    = busy_q;
    assign tx_done    = done_q;

endmodule

// File: tb/tb_uart_tx_block.sv
// tb_uart_tx_block: scoreboard bench for uart_tx_block.
// Expected line levels are queued per cycle when a frame is started.
module tb_uart_tx_block;

    localparam int CPB = 10;
    localparam int NB  = 8;
`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int FRAME  = (NB + 2 + PB) * CPB;
    localparam int FRAME2 = (5 + 2 + PB) * 2;

    logic       clk      = 1'b0;
    logic       n_rst    = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       serial_out, tx_busy, tx_done;

    logic       start2 = 1'b0;
    logic [4:0] data2  = 5'd0;
    logic       serial2, busy2, done2;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic exp_q[$];

    uart_tx_block #(.NUM_DATA_BITS(NB), .CLKS_PER_BIT(CPB)) u_dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .serial_out (serial_out),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done)
    );

    uart_tx_block #(.NUM_DATA_BITS(5), .CLKS_PER_BIT(2)) u_dut2 (
        .clk        (clk),
        .n_rst      (n_rst),
        .tx_start   (start2),
        .tx_data    (data2),
        .serial_out (serial2),
        .tx_busy    (busy2),
        .tx_done    (done2)
    );

    always #5 clk = ~clk;

    // Queue one expected line level per clock for a whole frame.
    task automatic push_frame(input logic [15:0] d, input int nb,
                              input int cpb);
        for (int c = 0; c < cpb; c++) exp_q.push_back(1'b0);
        for (int b = 0; b < nb; b++)
            for (int c = 0; c < cpb; c++) exp_q.push_back(d[b]);
`ifdef UART_TX_PARITY_EN
        begin
            logic p;
            p = 1'b0;
            for (int b = 0; b < nb; b++) p ^= d[b];
            for (int c = 0; c < cpb; c++) exp_q.push_back(p);
        end
`endif
        for (int c = 0; c < cpb; c++) exp_q.push_back(1'b1);
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (serial_out !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: ser=%b busy=%b done=%b want 1 0 0",
                     serial_out, tx_busy, tx_done);
        end
        n_tests++;
        if (serial2 !== 1'b1 || busy2 !== 1'b0 || done2 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset2: ser=%b busy=%b done=%b want 1 0 0",
                     serial2, busy2, done2);
        end
        n_rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_frame();
        logic e;
        tx_data  = 8'hA5;
        tx_start = 1'b1;
        push_frame(16'h00A5, NB, CPB);
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            n_tests++;
            e = exp_q.size() ? exp_q.pop_front() : 1'bx;
            if (serial_out !== e) begin
                n_fail++;
                $display("FAIL single_line cyc=%0d got=%b want=%b",
                         i + 1, serial_out, e);
            end
            n_tests++;
            if (tx_busy !== 1'b1 || tx_done !== 1'b0) begin
                n_fail++;
                $display("FAIL single_busy cyc=%0d busy=%b done=%b want 1 0",
                         i + 1, tx_busy, tx_done);
            end
            if (i == 0) tx_start = 1'b0;
        end
        @(negedge clk);
        n_tests++;
        if (tx_done !== 1'b1 || tx_busy !== 1'b0 || serial_out !== 1'b1) begin
            n_fail++;
            $display("FAIL single_done cyc=%0d done=%b busy=%b ser=%b want 1 0 1",
                     FRAME + 1, tx_done, tx_busy, serial_out);
        end
        @(negedge clk);
        n_tests++;
        if (tx_done !== 1'b0 || tx_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_after done=%b busy=%b want 0 0",
                     tx_done, tx_busy);
        end
    endtask

    task automatic test_busy_ignore();
        logic e;
        tx_data  = 8'h3C;
        tx_start = 1'b1;
        push_frame(16'h003C, NB, CPB);
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            n_tests++;
            e = exp_q.size() ? exp_q.pop_front() : 1'bx;
            if (serial_out !== e) begin
                n_fail++;
                $display("FAIL busy_line cyc=%0d got=%b want=%b",
                         i + 1, serial_out, e);
            end
            if (i == 0) tx_start = 1'b0;
            if (i == 2 * CPB) tx_data = 8'h81;
            if (i == 3 * CPB + 4) begin
                tx_start = 1'b1;
                tx_data  = 8'hFF;
            end
            if (i == 3 * CPB + 5) tx_start = 1'b0;
        end
        @(negedge clk);
        n_tests++;
        if (tx_done !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_done got=%b want=1", tx_done);
        end
        for (int i = 0; i < 3 * CPB; i++) begin
            @(negedge clk);
            n_tests++;
            if (serial_out !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
                n_fail++;
                $display("FAIL busy_no_second cyc=%0d ser=%b busy=%b done=%b",
                         i, serial_out, tx_busy, tx_done);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic e;
        tx_data  = 8'h00;
        tx_start = 1'b1;
        push_frame(16'h0000, NB, CPB);
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            n_tests++;
            e = exp_q.size() ? exp_q.pop_front() : 1'bx;
            if (serial_out !== e || tx_busy !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_first cyc=%0d ser=%b busy=%b want %b 1",
                         i + 1, serial_out, tx_busy, e);
            end
            if (i == 0) tx_data = 8'hFF;
        end
        @(negedge clk);
        n_tests++;
        if (tx_done !== 1'b1 || tx_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_done done=%b busy=%b want 1 0",
                     tx_done, tx_busy);
        end
        push_frame(16'h00FF, NB, CPB);
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            n_tests++;
            e = exp_q.size() ? exp_q.pop_front() : 1'bx;
            if (serial_out !== e || tx_busy !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_second cyc=%0d ser=%b busy=%b want %b 1",
                         i + 1, serial_out, tx_busy, e);
            end
            if (i == 0) tx_start = 1'b0;
        end
        @(negedge clk);
        n_tests++;
        if (tx_done !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_done2 got=%b want=1", tx_done);
        end
        @(negedge clk);
    endtask

    task automatic test_parity();
        logic       e;
        logic [7:0] v [2];
        v[0] = 8'h07;
        v[1] = 8'h03;
        for (int k = 0; k < 2; k++) begin
            tx_data  = v[k];
            tx_start = 1'b1;
            push_frame({8'h00, v[k]}, NB, CPB);
            for (int i = 0; i < FRAME; i++) begin
                @(negedge clk);
                n_tests++;
                e = exp_q.size() ? exp_q.pop_front() : 1'bx;
                if (serial_out !== e) begin
                    n_fail++;
                    $display("FAIL parity_line v=%h cyc=%0d got=%b want=%b",
                             v[k], i + 1, serial_out, e);
                end
`ifdef UART_TX_PARITY_EN
                if (i == (NB + 1) * CPB + 3) begin
                    n_tests++;
                    if (serial_out !== (k == 0)) begin
                        n_fail++;
                        $display("FAIL parity_bit v=%h got=%b want=%b",
                                 v[k], serial_out, (k == 0));
                    end
                end
`endif
                if (i == 0) tx_start = 1'b0;
            end
            @(negedge clk);
            n_tests++;
            if (tx_done !== 1'b1 || tx_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL parity_len v=%h done=%b busy=%b want 1 0",
                         v[k], tx_done, tx_busy);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_data();
        tx_data  = 8'h00;
        tx_start = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (i == 0) tx_start = 1'b0;
        end
        n_tests++;
        if (serial_out !== 1'b0 || tx_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_pre ser=%b busy=%b want 0 1",
                     serial_out, tx_busy);
        end
        n_rst = 1'b0;
        #1;
        n_tests++;
        if (serial_out !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_async ser=%b busy=%b done=%b want 1 0 0",
                     serial_out, tx_busy, tx_done);
        end
        exp_q.delete();
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        for (int i = 0; i < FRAME + 20; i++) begin
            @(negedge clk);
            n_tests++;
            if (serial_out !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_abandon cyc=%0d ser=%b busy=%b done=%b",
                         i, serial_out, tx_busy, tx_done);
            end
        end
    endtask

    task automatic test_timing_corner();
        logic e;
        data2  = 5'b10110;
        start2 = 1'b1;
        push_frame(16'b10110, 5, 2);
        for (int i = 0; i < FRAME2; i++) begin
            @(negedge clk);
            n_tests++;
            e = exp_q.size() ? exp_q.pop_front() : 1'bx;
            if (serial2 !== e || busy2 !== 1'b1) begin
                n_fail++;
                $display("FAIL corner cyc=%0d ser=%b busy=%b want %b 1",
                         i + 1, serial2, busy2, e);
            end
            if (i == 0) start2 = 1'b0;
        end
        @(negedge clk);
        n_tests++;
        if (done2 !== 1'b1 || busy2 !== 1'b0 || serial2 !== 1'b1) begin
            n_fail++;
            $display("FAIL corner_done done=%b busy=%b ser=%b want 1 0 1",
                     done2, busy2, serial2);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_busy_ignore();
        test_back_to_back();
        test_parity();
        test_reset_mid_data();
        test_timing_corner();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_left got=%0d want=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
